mux_scan_serializer: RTL and testbench
======================================

MUX_SCAN_SERIALIZER -- requirements
Module: mux_scan_serializer

Interface
REQ-001 Parameter: MSB_FIRST, 0, scan order (0: index 0..15; 1: index 15..0).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: load_valid  input  1  upstream word offered.
REQ-005 Port: load_data  input  16  parallel word to scan.
REQ-006 Port: load_ready  output  1  block accepts a word this cycle.
REQ-007 Port: ser_ready  input  1  downstream accepts current bit.
REQ-008 Port: ser_valid  output  1  ser_bit valid.
REQ-009 Port: ser_bit  output  1  selected bit, word[sel].
REQ-010 Port: sel  output  4  current 16:1 select index.
REQ-011 Port: last  output  1  current bit is final bit of word.

Function
REQ-012 SHALL implement FSM with states IDLE and SCAN only.
REQ-013 IDLE: load_ready=1, ser_valid=0, ser_bit=0, last=0, sel=start index (0 if MSB_FIRST=0, else 15).
REQ-014 Load handshake: load_valid&&load_ready at edge N SHALL capture load_data into word register, set cnt=start index, enter SCAN.
REQ-015 First bit SHALL be valid in cycle N+1 (one-cycle latency); ser_bit=word[cnt] combinationally from registers.
REQ-016 SCAN: load_ready=0, ser_valid=1, sel=cnt; load_valid SHALL be ignored and word register SHALL NOT change.
REQ-017 Bit transfer occurs only on ser_valid&&ser_ready; cnt SHALL then step +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1), 4-bit.
REQ-018 ser_ready=0: cnt, sel, ser_bit, last SHALL hold unchanged, no limit on stall length.
REQ-019 last=1 in SCAN when cnt equals end index (15 if MSB_FIRST=0, else 0).
REQ-020 Transfer with last=1 SHALL return FSM to IDLE with cnt=start index; no wrap into a second pass.
REQ-021 Exactly 16 transfers per accepted word; minimum word period 17 cycles (one IDLE cycle between words).

Reset
REQ-022 While rst_n=0 at an edge: state=IDLE, cnt=start index, word=16'h0000.
REQ-023 load_ready SHALL be 0 while rst_n=0 and 1 in first cycle after release.
REQ-024 Reset mid-SCAN SHALL abort the word: remaining bits discarded, no last pulse, ser_valid=0 next cycle.

Structure
REQ-025 Shared package SHALL hold state enum (IDLE, SCAN), WORD_W=16, SEL_W=4.
REQ-026 One sub-module scan_cnt4: 4-bit up/down counter with load, enable, terminal flag; selection logic stays in top.

Verification
REQ-027 Reset: rst_n=0 two cycles -> ser_valid=0, load_ready=0, sel=0; after release load_ready=1.
REQ-028 MSB_FIRST=0, load 16'b0001011101010111, ser_ready=1 -> ser_bit 1,1,1,0,1,0,1,0,1,1,1,0,1,0,0,0 on sel 0..15, last with sel=15, load_ready=1 next cycle.
REQ-029 Same word, ser_ready=0 for 3 cycles at sel=5 -> sel stays 5, ser_bit stays 0, word completes in 19 cycles.
REQ-030 MSB_FIRST=1, load 16'h8001 -> first bit 1 at sel=15, fourteen 0s, final 1 at sel=0 with last=1.
REQ-031 load_valid=1 with 16'hFFFF during SCAN of 16'h0000 -> load_ready=0, all 16 bits 0.
REQ-032 rst_n=0 one cycle at sel=7 -> next cycle ser_valid=0, sel=0; new load 16'h0001 yields first bit 1 at sel=0.

Source files
------------

// File: rtl/mux_scan_serializer_pkg.sv
// Shared types and widths for the 16:1 mux scan serializer.
package mux_scan_serializer_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // The first scanned index for a given scan order.
    function automatic logic [SEL_W-1:0] start_index(input bit msb_first);
        return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    endfunction

    // The final scanned index for a given scan order.
    function automatic logic [SEL_W-1:0] end_index(input bit msb_first);
        return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
    endfunction

endpackage

// File: rtl/mux_scan_serializer_scan_cnt4.sv
// 4-bit up/down select counter: reloads to the scan start, steps on enable,
// and flags the terminal index of the chosen direction.
import mux_scan_serializer_pkg::*;

module scan_cnt4 #(
    parameter bit DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] cnt,
    output logic             term
);

    localparam logic [SEL_W-1:0] START_VAL = start_index(DOWN);
    localparam logic [SEL_W-1:0] END_VAL   = end_index(DOWN);

    // Load wins over enable so a finishing word lands exactly on the start index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= START_VAL;
        end else if (load) begin
            cnt <= START_VAL;
        end else if (en) begin
            cnt <= DOWN ? cnt - 1'b1 : cnt + 1'b1;
        end
    end

    assign term = (cnt == END_VAL);

endmodule

// File: rtl/mux_scan_serializer.sv
// Captures a 16-bit word and streams it one bit per accepted handshake
// through a 16:1 select, in either scan order.
import mux_scan_serializer_pkg::*;

module mux_scan_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [WORD_W-1:0] load_data,
    output logic              load_ready,
    input  logic              ser_ready,
    output logic              ser_valid,
    output logic              ser_bit,
    output logic [SEL_W-1:0]  sel,
    output logic              last
);

    localparam logic [SEL_W-1:0] START_SEL = start_index(MSB_FIRST);

    state_t            state;
    state_t            state_next;
    logic [WORD_W-1:0] word;
    logic [SEL_W-1:0]  cnt;
    logic              term;
    logic              accept;
    logic              xfer;

    assign accept = load_valid && load_ready;
    assign xfer   = ser_valid && ser_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)       state_next = SCAN;
            SCAN: if (xfer && last) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: the word register carries a reset because its cleared value is
    // part of the defined post-reset state, unlike a wide data array would.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
        end else if (accept) begin
            word <= load_data;
        end
    end

    scan_cnt4 #(
        .DOWN (MSB_FIRST)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept || (xfer && last)),
        .en    (xfer),
        .cnt   (cnt),
        .term  (term)
    );

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        last       = 1'b0;
        sel        = START_SEL;
        case (state)
            IDLE: begin
                load_ready = rst_n;
            end
            SCAN: begin
                ser_valid = 1'b1;
                ser_bit   = word[cnt];
                sel       = cnt;
                last      = term;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Scoreboard bench for mux_scan_serializer: one instance per scan order,
// expected bits queued at load and popped on each transfer.
module tb_mux_scan_serializer;

    typedef struct packed {
        logic       b;
        logic [3:0] s;
        logic       l;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load_valid [2];
    logic [15:0] load_data  [2];
    logic        load_ready [2];
    logic        ser_ready  [2];
    logic        ser_valid  [2];
    logic        ser_bit    [2];
    logic [3:0]  sel        [2];
    logic        last       [2];

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   cyc;

    mux_scan_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid[0]),
        .load_data  (load_data[0]),
        .load_ready (load_ready[0]),
        .ser_ready  (ser_ready[0]),
        .ser_valid  (ser_valid[0]),
        .ser_bit    (ser_bit[0]),
        .sel        (sel[0]),
        .last       (last[0])
    );

    mux_scan_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid[1]),
        .load_data  (load_data[1]),
        .load_ready (load_ready[1]),
        .ser_ready  (ser_ready[1]),
        .ser_valid  (ser_valid[1]),
        .ser_bit    (ser_bit[1]),
        .sel        (sel[1]),
        .last       (last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Offers one word to instance d and follows it to completion. Optional
    // stall at a given sel, optional FFFF held on load during the scan, and
    // optional reset when a given sel is reached (aborts the word).
    task automatic send_word(input int d, input logic [15:0] w,
                             input int stall_sel, input int stall_len,
                             input bit hold_ff, input int rst_sel,
                             output int cycles);
        int   n;
        int   stalls;
        int   idx;
        bit   done;
        exp_t e;
        cycles = 0;
        stalls = stall_len;
        done   = 1'b0;

        n = 0;
        while (load_ready[d] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_load_ready", load_ready[d], 1);
        check("idle_ser_valid", ser_valid[d], 0);
        check("idle_last", last[d], 0);

        load_valid[d] = 1'b1;
        load_data[d]  = w;
        ser_ready[d]  = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) begin
            idx = (d == 1) ? 15 - k : k;
            e.b = w[idx];
            e.s = 4'(idx);
            e.l = (k == 15);
            sb.push_back(e);
        end
        if (hold_ff) load_data[d] = 16'hFFFF;
        else         load_valid[d] = 1'b0;
        check("first_bit_latency", ser_valid[d], 1);

        while (!done && cycles < 64) begin
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
                break;
            end
            e = sb[0];
            check("scan_ser_valid", ser_valid[d], 1);
            check("scan_load_ready", load_ready[d], 0);
            check("sel", sel[d], e.s);
            check("ser_bit", ser_bit[d], e.b);
            check("last", last[d], e.l);

            if (rst_sel == int'(sel[d])) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                check("abort_ser_valid", ser_valid[d], 0);
                check("abort_sel", sel[d], (d == 1) ? 15 : 0);
                check("abort_last", last[d], 0);
                check("abort_load_ready", load_ready[d], 0);
                rst_n = 1'b1;
                load_valid[d] = 1'b0;
                sb.delete();
                return;
            end

            if (stalls > 0 && int'(sel[d]) == stall_sel) begin
                ser_ready[d] = 1'b0;
                stalls--;
            end else begin
                ser_ready[d] = 1'b1;
                void'(sb.pop_front());
                done = e.l;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (!done) check("word_timeout", 0, 1);

        load_valid[d] = 1'b0;
        ser_ready[d]  = 1'b1;
        check("post_load_ready", load_ready[d], 1);
        check("post_ser_valid", ser_valid[d], 0);
        check("post_last", last[d], 0);
        check("post_sel", sel[d], (d == 1) ? 15 : 0);
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid[i] = 1'b0;
            load_data[i]  = 16'h0000;
            ser_ready[i]  = 1'b1;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_ser_valid", ser_valid[i], 0);
            check("rst_load_ready", load_ready[i], 0);
            check("rst_last", last[i], 0);
            check("rst_ser_bit", ser_bit[i], 0);
        end
        check("rst_sel_lsb_first", sel[0], 0);
        check("rst_sel_msb_first", sel[1], 15);
        rst_n = 1'b1;
        #1;
        check("release_load_ready0", load_ready[0], 1);
        check("release_load_ready1", load_ready[1], 1);

        send_word(0, 16'b0001011101010111, -1, 0, 1'b0, -1, cyc);
        check("cycles_no_stall", cyc, 16);

        send_word(0, 16'b0001011101010111, 5, 3, 1'b0, -1, cyc);
        check("cycles_stall3", cyc, 19);

        send_word(1, 16'h8001, -1, 0, 1'b0, -1, cyc);
        check("cycles_msb_first", cyc, 16);

        send_word(0, 16'h0000, -1, 0, 1'b1, -1, cyc);
        check("cycles_load_ignored", cyc, 16);

        send_word(0, 16'hA5C3, -1, 0, 1'b0, 7, cyc);
        send_word(0, 16'h0001, -1, 0, 1'b0, -1, cyc);
        check("cycles_after_abort", cyc, 16);

        send_word(1, 16'($urandom), 9, 2, 1'b0, -1, cyc);
        check("cycles_msb_stall2", cyc, 18);

        send_word(0, 16'($urandom), 15, 4, 1'b0, -1, cyc);
        check("cycles_stall_on_last", cyc, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
